timer_controller: RTL and testbench

TIMER_CONTROLLER -- requirements
Module: timer_controller

---
 rtl/timer_pkg.sv | 20 ++
 rtl/button_edge.sv | 26 ++
 rtl/timer_controller.sv | 146 ++++++++++++++
 tb/tb_timer_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared state encodings, default timing parameters and the digit check
// used by the countdown timer controller.
package timer_pkg;

    localparam int unsigned TICK_DIV_DEFAULT    = 50_000_000;
    localparam int unsigned ALARM_TICKS_DEFAULT = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_EXPIRED = 3'd4
    } timer_state_e;

    function automatic logic digits_valid(input logic [3:0] tens, input logic [3:0] ones);
        return (tens <= 4'd9) && (ones <= 4'd9);
    endfunction

endpackage

// File: rtl/button_edge.sv
// Rising-edge detector for one button level.
// The detector only arms once the button has been seen released after reset.
module button_edge (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic rise
);

    logic prev;
    logic armed;

    // A button already held when reset is released must not count as a press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= button;
            armed <= armed | ~button;
        end
    end

    assign rise = button & ~prev & armed;

endmodule

// File: rtl/timer_controller.sv
// Control FSM for a two-digit BCD countdown timer: button handling,
// one-second prescaler, load/decrement strobes and the expiry alarm.
module timer_controller
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int unsigned ALARM_TICKS = ALARM_TICKS_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       reconfigure,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] tens_time,
    input  logic [3:0] ones_time,
    input  logic       zero_reached,
    output logic       load_pulse,
    output logic       dec_pulse,
    output logic       alarm,
    output logic [2:0] state_out,
    output logic       config_error
);

    localparam int unsigned PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    ALARM_LAST = 4'(ALARM_TICKS - 1);

    timer_state_e  state;
    logic [PW-1:0] presc;
    logic [3:0]    alarm_cnt;

    logic rec_ev;
    logic pause_ev;
    logic start_ev;
    logic cfg_ok;
    logic pause_go;
    logic start_go;
    logic wrap;

    button_edge u_rec_edge (
        .clock  (clock),
        .reset  (reset),
        .button (reconfigure),
        .rise   (rec_ev)
    );

    button_edge u_pause_edge (
        .clock  (clock),
        .reset  (reset),
        .button (pause),
        .rise   (pause_ev)
    );

    button_edge u_start_edge (
        .clock  (clock),
        .reset  (reset),
        .button (start),
        .rise   (start_ev)
    );

    // Reconfigure outranks pause, which outranks start; a rejected
    // reconfigure still masks the lower-priority events of that cycle.
    assign cfg_ok   = digits_valid(tens_time, ones_time);
    assign pause_go = pause_ev & ~rec_ev;
    assign start_go = start_ev & ~rec_ev & ~pause_ev;
    assign wrap     = (presc == PRESC_LAST);

    assign state_out = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            presc        <= '0;
            alarm_cnt    <= '0;
            load_pulse   <= 1'b0;
            dec_pulse    <= 1'b0;
            alarm        <= 1'b0;
            config_error <= 1'b0;
        end else begin
            load_pulse <= 1'b0;
            dec_pulse  <= 1'b0;
            if (rec_ev && cfg_ok) begin
                state        <= ST_LOAD;
                load_pulse   <= 1'b1;
                config_error <= 1'b0;
                alarm        <= 1'b0;
                presc        <= '0;
                alarm_cnt    <= '0;
            end else begin
                if (rec_ev) begin
                    config_error <= 1'b1;
                end
                case (state)
                    ST_LOAD: begin
                        state <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (start_go && !zero_reached) begin
                            state <= ST_RUN;
                            presc <= '0;
                        end
                    end
                    ST_RUN: begin
                        // Expiry wins over a coinciding wrap: no strobe for it.
                        if (zero_reached) begin
                            state     <= ST_EXPIRED;
                            presc     <= '0;
                            alarm_cnt <= '0;
                            alarm     <= 1'b1;
                        end else if (pause_go) begin
                            state <= ST_PAUSE;
                        end else if (wrap) begin
                            presc     <= '0;
                            dec_pulse <= 1'b1;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        if (start_go) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_EXPIRED: begin
                        if (wrap) begin
                            presc <= '0;
                            if (alarm_cnt == ALARM_LAST) begin
                                state     <= ST_IDLE;
                                alarm     <= 1'b0;
                                alarm_cnt <= '0;
                            end else begin
                                alarm_cnt <= alarm_cnt + 4'd1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_controller.sv
// Bench for timer_controller: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model of the timer rules.
module tb_timer_controller;

    localparam int TD = 4;
    localparam int AT = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       reconfigure = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] tens_time = 4'd0;
    logic [3:0] ones_time = 4'd0;
    logic       zero_reached = 1'b0;
    logic       load_pulse;
    logic       dec_pulse;
    logic       alarm;
    logic [2:0] state_out;
    logic       config_error;

    always #5 clock = ~clock;

    timer_controller #(
        .TICK_DIV    (TD),
        .ALARM_TICKS (AT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .reconfigure  (reconfigure),
        .start        (start),
        .pause        (pause),
        .tens_time    (tens_time),
        .ones_time    (ones_time),
        .zero_reached (zero_reached),
        .load_pulse   (load_pulse),
        .dec_pulse    (dec_pulse),
        .alarm        (alarm),
        .state_out    (state_out),
        .config_error (config_error)
    );

    logic [6:0] act;
    assign act = {state_out, load_pulse, dec_pulse, alarm, config_error};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: run time is tracked as elapsed running cycles, so a
    // one-second strobe is due whenever that total is a multiple of TD.
    int m_state;
    int run_el;
    int exp_el;
    bit m_load, m_dec, m_alarm, m_cfg;
    bit pr_r, pr_p, pr_s;

    function automatic void model_reset();
        m_state = 0;
        run_el  = 0;
        exp_el  = 0;
        m_load  = 0;
        m_dec   = 0;
        m_alarm = 0;
        m_cfg   = 0;
        // Buttons are treated as held across reset: only a fresh press counts.
        pr_r    = 1;
        pr_p    = 1;
        pr_s    = 1;
    endfunction

    function automatic void model_step(input bit r, input bit p, input bit s,
                                       input logic [3:0] t, input logic [3:0] o,
                                       input bit zr);
        bit ev_r, ev_p, ev_s;
        ev_r = r && !pr_r;
        ev_p = p && !pr_p && !ev_r;
        ev_s = s && !pr_s && !ev_r && !ev_p;
        pr_r = r;
        pr_p = p;
        pr_s = s;
        m_load = 0;
        m_dec  = 0;
        if (ev_r && t <= 9 && o <= 9) begin
            m_state = 1;
            m_load  = 1;
            m_cfg   = 0;
            m_alarm = 0;
            return;
        end
        if (ev_r) m_cfg = 1;
        case (m_state)
            1: m_state = 0;
            0: if (ev_s && !zr) begin
                m_state = 2;
                run_el  = 0;
            end
            2: begin
                if (zr) begin
                    m_state = 4;
                    exp_el  = 0;
                    m_alarm = 1;
                end else if (ev_p) begin
                    m_state = 3;
                end else begin
                    run_el++;
                    if (run_el % TD == 0) m_dec = 1;
                end
            end
            3: if (ev_s) m_state = 2;
            4: begin
                exp_el++;
                if (exp_el == AT * TD) begin
                    m_state = 0;
                    m_alarm = 0;
                end
            end
            default: m_state = 0;
        endcase
    endfunction

    function automatic logic [6:0] exp_vec();
        return {3'(m_state), m_load, m_dec, m_alarm, m_cfg};
    endfunction

    task automatic tick(input bit r, input bit p, input bit s,
                        input logic [3:0] t, input logic [3:0] o, input bit zr);
        reconfigure  = r;
        pause        = p;
        start        = s;
        tens_time    = t;
        ones_time    = o;
        zero_reached = zr;
        @(posedge clock);
        model_step(r, p, s, t, o, zr);
        #1;
        check("outs", 32'(act), 32'(exp_vec()));
    endtask

    task automatic step0();
        tick(0, 0, 0, 4'd2, 4'd5, 0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_reset();
        #1;
        check("reset_outs", 32'(act), 32'd0);
        repeat (n) begin
            @(posedge clock);
            #1;
            check("reset_hold", 32'(act), 32'd0);
        end
        reset = 1'b1;
    endtask

    int lat;
    int hi;
    int guard;
    bit rr, rp, rs, rz;
    logic [3:0] rt, ro;

    initial begin
        model_reset();
        #2;
        check("reset_outs", 32'(act), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        step0();
        step0();

        // Load 2/5, start, then strobe cadence.
        tick(1, 0, 0, 4'd2, 4'd5, 0);
        check("load_pulse", 32'(load_pulse), 32'd1);
        step0();
        step0();
        tick(0, 0, 1, 4'd2, 4'd5, 0);
        check("run_entry", 32'(state_out), 32'd2);
        lat = 0;
        do begin step0(); lat++; end while (!dec_pulse && lat < 20);
        check("first_dec_lat", 32'(lat), 32'd4);
        lat = 0;
        do begin step0(); lat++; end while (!dec_pulse && lat < 20);
        check("dec_period", 32'(lat), 32'd4);

        // Pause two cycles into a second, hold, resume.
        step0();
        step0();
        tick(0, 1, 0, 4'd2, 4'd5, 0);
        check("pause_entry", 32'(state_out), 32'd3);
        repeat (10) step0();
        tick(0, 0, 1, 4'd2, 4'd5, 0);
        lat = 0;
        do begin step0(); lat++; end while (!dec_pulse && lat < 20);
        check("resume_lat", 32'(lat), 32'd2);

        // zero_reached on a wrap cycle.
        step0();
        step0();
        step0();
        tick(0, 0, 0, 4'd2, 4'd5, 1);
        check("wrap_vs_zero", 32'(dec_pulse), 32'd0);
        check("expired", 32'(state_out), 32'd4);
        hi = alarm ? 1 : 0;
        guard = 0;
        while (alarm && guard < 40) begin
            step0();
            if (alarm) hi++;
            guard++;
        end
        check("alarm_cycles", 32'(hi), 32'(AT * TD));
        check("exp_to_idle", 32'(state_out), 32'd0);

        // Rejected then accepted reconfigure.
        tick(1, 0, 0, 4'hA, 4'd3, 0);
        check("cfg_err_set", 32'(config_error), 32'd1);
        check("cfg_err_noload", 32'(load_pulse), 32'd0);
        step0();
        tick(1, 0, 0, 4'd2, 4'd5, 0);
        check("cfg_err_clear", 32'(config_error), 32'd0);
        step0();

        // All three buttons together while running.
        tick(0, 0, 1, 4'd2, 4'd5, 0);
        step0();
        step0();
        tick(1, 1, 1, 4'd2, 4'd5, 0);
        check("combo_load", 32'(state_out), 32'd1);
        step0();
        step0();

        // Reset mid-run with start held through release.
        tick(0, 0, 1, 4'd2, 4'd5, 0);
        tick(0, 0, 1, 4'd2, 4'd5, 0);
        tick(0, 0, 1, 4'd2, 4'd5, 0);
        do_reset(3);
        repeat (6) tick(0, 0, 1, 4'd2, 4'd5, 0);
        check("no_run_after_reset", 32'(state_out), 32'd0);
        step0();
        tick(0, 0, 1, 4'd2, 4'd5, 0);
        check("rearmed_start", 32'(state_out), 32'd2);

        // Random button traffic.
        rr = 0; rp = 0; rs = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) rr = !rr;
            if ($urandom_range(0, 5) == 0) rp = !rp;
            if ($urandom_range(0, 4) == 0) rs = !rs;
            if ($urandom_range(0, 7) == 0) begin
                rt = 4'($urandom_range(0, 15));
                ro = 4'($urandom_range(0, 15));
            end else begin
                rt = 4'($urandom_range(0, 9));
                ro = 4'($urandom_range(0, 9));
            end
            rz = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
            tick(rr, rp, rs, rt, ro, rz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
